// File: rtl/regs_param.sv
// Parametrised nibble register file with handshaked memory write port.
// Optional SP wrap guard: define REGS_SP_GUARD_EN.
module regs_param #(
    parameter int DATA_W  = 4,
    parameter int NUM_IDX = 2,
    parameter int PAGE_W  = 4,
    parameter int ADDR_W  = 12
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          current_cycle,
    input  logic [4:0]          src_sel,
    input  logic [4:0]          dst_sel,
    input  logic [2:0]          inc_sel,
    input  logic [DATA_W-1:0]   alu,
    input  logic [2*DATA_W-1:0] immed,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rd_data,
    output logic                mem_wr_en,
    output logic [DATA_W-1:0]   mem_wr_data,
    input  logic                mem_wr_ready,
    output logic                busy,
    output logic                sp_fault
);

    localparam int BW = 2 * DATA_W;
    localparam logic [1:0] CYCLE_REG_FETCH = 2'd1;
    localparam logic [1:0] CYCLE_REG_WRITE = 2'd2;

    logic [DATA_W-1:0] a, b, tempa, tempb;
    logic [ADDR_W-1:0] idx [NUM_IDX];
    logic [BW-1:0]     sp;
    logic [ADDR_W-1:0] wr_addr;

    logic [DATA_W-1:0] src_val, bus;
    logic              src_mem, dst_mem;
    logic [ADDR_W-1:0] src_addr, dst_addr;
    logic              is_fetch, is_write;

    assign is_fetch = (current_cycle == CYCLE_REG_FETCH);
    assign is_write = (current_cycle == CYCLE_REG_WRITE);

    always_comb begin
        src_val  = '0;
        src_mem  = 1'b0;
        src_addr = '0;
        unique case (src_sel)
            5'd0: src_val = a;
            5'd1: src_val = b;
            5'd2: src_val = tempa;
            5'd3: src_val = tempb;
            5'd4: src_val = alu;
            5'd5: src_val = immed[DATA_W-1:0];
            5'd6: src_val = sp[DATA_W-1:0];
            5'd7: src_val = sp[BW-1:DATA_W];
            5'd8: begin
                src_mem  = 1'b1;
                src_addr = ADDR_W'(sp);
            end
            5'd9: begin
                src_mem  = 1'b1;
                src_addr = ADDR_W'(immed);
            end
            default: ;
        endcase
        for (int i = 0; i < NUM_IDX; i++) begin
            if (src_sel[4] && int'(src_sel[3:2]) == i) begin
                unique case (src_sel[1:0])
                    2'd0: src_val = idx[i][DATA_W-1:0];
                    2'd1: src_val = idx[i][BW-1:DATA_W];
                    2'd2: src_val = DATA_W'(idx[i][ADDR_W-1:BW]);
                    default: begin
                        src_mem  = 1'b1;
                        src_addr = idx[i];
                    end
                endcase
            end
        end
    end

    always_comb begin
        dst_mem  = 1'b0;
        dst_addr = '0;
        unique case (dst_sel)
            5'd8: begin
                dst_mem  = 1'b1;
                dst_addr = ADDR_W'(sp);
            end
            5'd9: begin
                dst_mem  = 1'b1;
                dst_addr = ADDR_W'(immed);
            end
            default: ;
        endcase
        for (int i = 0; i < NUM_IDX; i++) begin
            if (dst_sel[4] && int'(dst_sel[3:2]) == i
                && dst_sel[1:0] == 2'd3) begin
                dst_mem  = 1'b1;
                dst_addr = idx[i];
            end
        end
    end

    // A pending write owns the address bus, so memory sources see it too.
    assign bus      = src_mem ? mem_rd_data : src_val;
    assign mem_addr = mem_wr_en ? wr_addr : (src_mem ? src_addr : '0);
    assign busy     = mem_wr_en & ~mem_wr_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a           <= '0;
            b           <= '0;
            tempa       <= '0;
            tempb       <= '0;
            sp          <= '0;
            wr_addr     <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
            for (int i = 0; i < NUM_IDX; i++) idx[i] <= '0;
        end else begin
            if (is_write) begin
                unique case (dst_sel)
                    5'd0: a <= bus;
                    5'd1: b <= bus;
                    5'd2: tempa <= bus;
                    5'd3: tempb <= bus;
                    5'd6: sp[DATA_W-1:0] <= bus;
                    5'd7: sp[BW-1:DATA_W] <= bus;
                    default: ;
                endcase
                for (int i = 0; i < NUM_IDX; i++) begin
                    if (dst_sel[4] && int'(dst_sel[3:2]) == i) begin
                        unique case (dst_sel[1:0])
                            2'd0: idx[i][DATA_W-1:0] <= bus;
                            2'd1: idx[i][BW-1:DATA_W] <= bus;
                            2'd2: idx[i][ADDR_W-1:BW] <= PAGE_W'(bus);
                            default: ;
                        endcase
                    end
                end
                // Increments come last so they override the bus write.
                if (inc_sel == 3'd1) sp <= sp + 1'b1;
                else if (inc_sel == 3'd2) sp <= sp - 1'b1;
                for (int i = 0; i < NUM_IDX; i++) begin
                    if (inc_sel == 3'(4 + i))
                        idx[i][BW-1:0] <= idx[i][BW-1:0] + 1'b1;
                end
            end
            if (mem_wr_en) begin
                if (mem_wr_ready) mem_wr_en <= 1'b0;
            end else if (is_fetch && dst_mem) begin
                mem_wr_en   <= 1'b1;
                wr_addr     <= dst_addr;
                mem_wr_data <= bus;
            end
        end
    end

`ifdef REGS_SP_GUARD_EN
    logic fault_q;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fault_q <= 1'b0;
        end else if (is_write) begin
            if ((inc_sel == 3'd1 && sp == '1)
                || (inc_sel == 3'd2 && sp == '0))
                fault_q <= 1'b1;
        end
    end
    assign sp_fault = fault_q;
`else
    assign sp_fault = 1'b0;
`endif

endmodule
